// File: rtl/regfile_wb_sequencer.sv
// Writeback sequencer driving the register file write port (WE3/A3/WD3):
// ALU results, blocking load completion with extension, x0 suppression and RAW hazards.
// Optional macro WB_FWD_EN adds a writeback forwarding path (fwd1/fwd2/fwd_data).
module regfile_wb_sequencer #(
  parameter int Data_Width   = 32,
  parameter int addres_width = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ex_valid,
  input  logic                    ex_reg_write,
  input  logic                    ex_is_load,
  input  logic [addres_width-1:0] ex_rd,
  input  logic [Data_Width-1:0]   ex_result,
  input  logic [2:0]              ex_funct3,
  input  logic [1:0]              ex_addr_lo,
  input  logic                    mem_ready,
  input  logic [Data_Width-1:0]   mem_rdata,
  output logic                    WE3,
  output logic [addres_width-1:0] A3,
  output logic [Data_Width-1:0]   WD3,
  output logic                    stall,
  input  logic [addres_width-1:0] chk_a1,
  input  logic [addres_width-1:0] chk_a2,
  output logic                    hz1,
  output logic                    hz2
`ifdef WB_FWD_EN
  ,
  output logic                    fwd1,
  output logic                    fwd2,
  output logic [Data_Width-1:0]   fwd_data
`endif
);

  typedef enum logic {IDLE, WAIT_MEM} state_t;

  state_t                  state, state_d;
  logic [addres_width-1:0] pending_rd, pending_rd_d;
  logic [2:0]              pending_f3, pending_f3_d;
  logic [1:0]              pending_lo, pending_lo_d;
  logic                    pending_we, pending_we_d;
  logic                    we_d;
  logic [addres_width-1:0] a3_d;
  logic [Data_Width-1:0]   wd_d;

  // Byte lane from the low address bits, halfword lane from bit 1.
  function automatic logic [Data_Width-1:0] load_ext(input logic [2:0] f3,
                                                      input logic [1:0] lo,
                                                      input logic [Data_Width-1:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lo, 3'b000} +: 8];
    h = w[{lo[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  load_ext = {{(Data_Width-8){b[7]}}, b};
      3'b100:  load_ext = {{(Data_Width-8){1'b0}}, b};
      3'b001:  load_ext = {{(Data_Width-16){h[15]}}, h};
      3'b101:  load_ext = {{(Data_Width-16){1'b0}}, h};
      default: load_ext = w;
    endcase
  endfunction

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d      = state;
    pending_rd_d = pending_rd;
    pending_f3_d = pending_f3;
    pending_lo_d = pending_lo;
    pending_we_d = pending_we;
    we_d         = 1'b0;
    a3_d         = A3;
    wd_d         = WD3;
    case (state)
      IDLE: begin
        if (ex_valid && ex_is_load) begin
          pending_rd_d = ex_rd;
          pending_f3_d = ex_funct3;
          pending_lo_d = ex_addr_lo;
          pending_we_d = ex_reg_write && (ex_rd != '0);
          state_d      = WAIT_MEM;
        end else if (ex_valid && ex_reg_write) begin
          we_d = (ex_rd != '0);
          a3_d = ex_rd;
          wd_d = ex_result;
        end
      end
      WAIT_MEM: begin
        // Execute-side inputs are frozen by stall; only the cache response matters.
        if (mem_ready) begin
          we_d    = pending_we;
          a3_d    = pending_rd;
          wd_d    = load_ext(pending_f3, pending_lo, mem_rdata);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pending_rd <= '0;
      pending_f3 <= '0;
      pending_lo <= '0;
      pending_we <= 1'b0;
      WE3        <= 1'b0;
      A3         <= '0;
      WD3        <= '0;
    end else begin
      state      <= state_d;
      pending_rd <= pending_rd_d;
      pending_f3 <= pending_f3_d;
      pending_lo <= pending_lo_d;
      pending_we <= pending_we_d;
      WE3        <= we_d;
      A3         <= a3_d;
      WD3        <= wd_d;
    end
  end

  assign stall = (state == WAIT_MEM);

  // Term A: load still outstanding. Term B: write commits at the next edge,
  // so a same-cycle register file read would see the stale value.
  logic load_hit1, load_hit2, wb_hit1, wb_hit2;
  always_comb begin
    load_hit1 = stall && pending_we && (chk_a1 == pending_rd);
    load_hit2 = stall && pending_we && (chk_a2 == pending_rd);
    wb_hit1   = WE3 && (chk_a1 == A3);
    wb_hit2   = WE3 && (chk_a2 == A3);
  end

`ifdef WB_FWD_EN
  assign fwd1     = wb_hit1 && (chk_a1 != '0);
  assign fwd2     = wb_hit2 && (chk_a2 != '0);
  assign fwd_data = WD3;
  assign hz1      = load_hit1 && (chk_a1 != '0);
  assign hz2      = load_hit2 && (chk_a2 != '0);
`else
  assign hz1 = (load_hit1 || wb_hit1) && (chk_a1 != '0);
  assign hz2 = (load_hit2 || wb_hit2) && (chk_a2 != '0);
`endif

endmodule

// File: tb/tb_regfile_wb_sequencer.sv
// Table-driven bench for regfile_wb_sequencer plus a hand-written reset-during-load sequence.
// Each row's inputs are driven for one cycle; its expectations describe that same cycle.
module tb_regfile_wb_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_reg_write, ex_is_load;
  logic [4:0]  ex_rd;
  logic [31:0] ex_result;
  logic [2:0]  ex_funct3;
  logic [1:0]  ex_addr_lo;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        WE3;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic        stall;
  logic [4:0]  chk_a1, chk_a2;
  logic        hz1, hz2;
`ifdef WB_FWD_EN
  logic        fwd1, fwd2;
  logic [31:0] fwd_data;
`endif

  always #5 clk = ~clk;

  regfile_wb_sequencer dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load),
    .ex_rd(ex_rd), .ex_result(ex_result), .ex_funct3(ex_funct3), .ex_addr_lo(ex_addr_lo),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .WE3(WE3), .A3(A3), .WD3(WD3), .stall(stall),
    .chk_a1(chk_a1), .chk_a2(chk_a2), .hz1(hz1), .hz2(hz2)
`ifdef WB_FWD_EN
    , .fwd1(fwd1), .fwd2(fwd2), .fwd_data(fwd_data)
`endif
  );

  typedef struct {
    logic        v, rw, ld;
    logic [4:0]  rd;
    logic [31:0] res;
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic        mr;
    logic [31:0] rdata;
    logic [4:0]  a1, a2;
    logic        e_we;
    logic [4:0]  e_a3;
    logic [31:0] e_wd;
    logic        e_chkd;  // compare A3/WD3 on this row
    logic        e_stall, e_hz1, e_hz2;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    ex_valid = 0; ex_reg_write = 0; ex_is_load = 0; ex_rd = 0; ex_result = 0;
    ex_funct3 = 0; ex_addr_lo = 0; mem_ready = 0; mem_rdata = 0; chk_a1 = 0; chk_a2 = 0;
  endtask

  initial begin
    //              v  rw ld rd  res           f3    lo mr rdata         a1  a2   we a3  wd            chkd st hz1 hz2
    vecs.push_back('{0, 0, 0, 0, 32'h0,        3'd0, 0, 0, 32'h0,        0,  0,   0, 0,  32'h0,        1, 0, 0, 0}); // reset state
    vecs.push_back('{1, 1, 0, 5, 32'h1234,     3'd0, 0, 0, 32'h0,        0,  0,   0, 0,  32'h0,        1, 0, 0, 0}); // ALU rd5
    vecs.push_back('{0, 0, 0, 0, 32'h0,        3'd0, 0, 0, 32'h0,        5,  0,   1, 5,  32'h1234,     1, 0, 1, 0});
    vecs.push_back('{1, 1, 0, 0, 32'hFFFF,     3'd0, 0, 0, 32'h0,        0,  0,   0, 0,  32'h0,        0, 0, 0, 0}); // ALU rd0
    vecs.push_back('{0, 0, 0, 0, 32'h0,        3'd0, 0, 0, 32'h0,        0,  0,   0, 0,  32'h0,        0, 0, 0, 0});
    vecs.push_back('{1, 1, 1, 7, 32'h0,        3'd0, 2, 0, 32'h0,        7,  0,   0, 0,  32'h0,        0, 0, 0, 0}); // LB rd7 lo2
    vecs.push_back('{1, 1, 0, 9, 32'h55,       3'd0, 0, 0, 32'h0,        7,  0,   0, 0,  32'h0,        0, 1, 1, 0}); // ignored ALU
    vecs.push_back('{0, 0, 0, 0, 32'h0,        3'd0, 0, 0, 32'h0,        7,  0,   0, 0,  32'h0,        0, 1, 1, 0});
    vecs.push_back('{0, 0, 0, 0, 32'h0,        3'd0, 0, 1, 32'h0080FF00, 7,  0,   0, 0,  32'h0,        0, 1, 1, 0});
    vecs.push_back('{0, 0, 0, 0, 32'h0,        3'd0, 0, 1, 32'h12345678, 7,  0,   1, 7,  32'hFFFFFF80, 1, 0, 1, 0}); // mr in IDLE
    vecs.push_back('{1, 1, 1, 10, 32'h0,       3'd5, 2, 0, 32'h0,        0,  10,  0, 0,  32'h0,        0, 0, 0, 0}); // LHU rd10
    vecs.push_back('{0, 0, 0, 0, 32'h0,        3'd0, 0, 1, 32'h80011234, 0,  10,  0, 0,  32'h0,        0, 1, 0, 1}); // ready 1st cycle
    vecs.push_back('{1, 1, 1, 11, 32'h0,       3'd1, 2, 0, 32'h0,        0,  10,  1, 10, 32'h00008001, 1, 0, 0, 1}); // LH back-to-back
    vecs.push_back('{0, 0, 0, 0, 32'h0,        3'd0, 0, 1, 32'h80011234, 0,  11,  0, 0,  32'h0,        0, 1, 0, 1});
    vecs.push_back('{1, 0, 1, 12, 32'h0,       3'd2, 0, 0, 32'h0,        0,  11,  1, 11, 32'hFFFF8001, 1, 0, 0, 1}); // LW no write
    vecs.push_back('{0, 0, 0, 0, 32'h0,        3'd0, 0, 1, 32'hDEADBEEF, 12, 0,   0, 0,  32'h0,        0, 1, 0, 0});
    vecs.push_back('{1, 1, 1, 13, 32'h0,       3'd4, 3, 0, 32'h0,        12, 0,   0, 0,  32'h0,        0, 0, 0, 0}); // LBU rd13 lo3
    vecs.push_back('{0, 0, 0, 0, 32'h0,        3'd0, 0, 1, 32'h9A000000, 13, 0,   0, 0,  32'h0,        0, 1, 1, 0});
    vecs.push_back('{1, 1, 0, 31, 32'hFFFFFFFF, 3'd0, 0, 0, 32'h0,       0,  0,   1, 13, 32'h0000009A, 1, 0, 0, 0}); // ALU rd31
    vecs.push_back('{0, 0, 0, 0, 32'h0,        3'd0, 0, 0, 32'h0,        31, 31,  1, 31, 32'hFFFFFFFF, 1, 0, 1, 1});
    vecs.push_back('{0, 0, 0, 0, 32'h0,        3'd0, 0, 0, 32'h0,        31, 31,  0, 0,  32'h0,        0, 0, 0, 0});

    drive_idle();
    rst = 1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = 0;
      ex_valid = vecs[i].v; ex_reg_write = vecs[i].rw; ex_is_load = vecs[i].ld;
      ex_rd = vecs[i].rd; ex_result = vecs[i].res; ex_funct3 = vecs[i].f3;
      ex_addr_lo = vecs[i].lo; mem_ready = vecs[i].mr; mem_rdata = vecs[i].rdata;
      chk_a1 = vecs[i].a1; chk_a2 = vecs[i].a2;
      #1;
      check($sformatf("row%0d WE3", i), 32'(WE3), 32'(vecs[i].e_we));
      check($sformatf("row%0d stall", i), 32'(stall), 32'(vecs[i].e_stall));
      if (vecs[i].e_chkd) begin
        check($sformatf("row%0d A3", i), 32'(A3), 32'(vecs[i].e_a3));
        check($sformatf("row%0d WD3", i), WD3, vecs[i].e_wd);
      end
`ifdef WB_FWD_EN
      // Write-cycle hazards become forwards; WE3 is never high while stalled.
      check($sformatf("row%0d fwd1", i), 32'(fwd1),
            32'(vecs[i].e_we && vecs[i].a1 == vecs[i].e_a3 && vecs[i].a1 != 0));
      check($sformatf("row%0d fwd2", i), 32'(fwd2),
            32'(vecs[i].e_we && vecs[i].a2 == vecs[i].e_a3 && vecs[i].a2 != 0));
      if (vecs[i].e_we) check($sformatf("row%0d fwd_data", i), fwd_data, vecs[i].e_wd);
      check($sformatf("row%0d hz1", i), 32'(hz1), 32'(vecs[i].e_stall && vecs[i].e_hz1));
      check($sformatf("row%0d hz2", i), 32'(hz2), 32'(vecs[i].e_stall && vecs[i].e_hz2));
`else
      check($sformatf("row%0d hz1", i), 32'(hz1), 32'(vecs[i].e_hz1));
      check($sformatf("row%0d hz2", i), 32'(hz2), 32'(vecs[i].e_hz2));
`endif
      @(posedge clk);
    end

    // Reset while waiting on a load: the late response must never write.
    @(negedge clk);
    drive_idle();
    ex_valid = 1; ex_reg_write = 1; ex_is_load = 1; ex_rd = 3; ex_funct3 = 3'd2;
    @(posedge clk);
    @(negedge clk);
    drive_idle();
    chk_a1 = 3;
    #1;
    check("rstseq stall before reset", 32'(stall), 32'd1);
    check("rstseq hz1 pending", 32'(hz1), 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1; mem_ready = 1; mem_rdata = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    check("rstseq A3 after reset", 32'(A3), 32'd0);
    check("rstseq WD3 after reset", WD3, 32'd0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rstseq stall c%0d", k), 32'(stall), 32'd0);
      check($sformatf("rstseq WE3 c%0d", k), 32'(WE3), 32'd0);
      check($sformatf("rstseq hz1 c%0d", k), 32'(hz1), 32'd0);
      @(posedge clk);
      @(negedge clk);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
